sync_up_counter: RTL

Parameterised synchronous modulo-N up counter built from toggle flip-flop cells, with enable, parallel load and cascade carry. It is the count-up counterpart of the team's 4-bit synchronous down counter: same clocking, reset and T-cell structure, opposite count direction. It adds a load path and terminal-count/carry signals so instances can be chained into wider or decade counters.

---
 rtl/sync_up_counter_pkg.sv | 34 +++
 rtl/sync_up_counter_tff_cell.sv | 54 +++++
 rtl/sync_up_counter.sv | 101 ++++++++++
 3 files changed

// File: rtl/sync_up_counter_pkg.sv
// -----------------------------------------------------------------------------
// sync_up_counter_pkg
//
// Shared definitions for the synchronous counter family (up counter now, the
// parameterised down counter later).
//   - MIN_WIDTH / MAX_WIDTH / MIN_MODULUS : legal parameter bounds
//   - max_modulus(width)                  : largest modulus a width can hold
//   - modulus_ok(width, modulus)          : parameter legality predicate
//   - clamp_load(val, modulus)            : min(val, modulus-1), used so a
//                                           parallel load can never place the
//                                           counter outside its sequence
// -----------------------------------------------------------------------------
package sync_up_counter_pkg;

    localparam int unsigned MIN_WIDTH   = 1;
    localparam int unsigned MAX_WIDTH   = 16;
    localparam int unsigned MIN_MODULUS = 2;

    function automatic int unsigned max_modulus(input int unsigned width);
        return 32'd1 << width;
    endfunction

    function automatic bit modulus_ok(input int unsigned width,
                                      input int unsigned modulus);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
               (modulus >= MIN_MODULUS) && (modulus <= max_modulus(width));
    endfunction

    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulus);
        return (val < modulus) ? val : (modulus - 32'd1);
    endfunction

endpackage

// File: rtl/sync_up_counter_tff_cell.sv
// -----------------------------------------------------------------------------
// tff_cell
//
// One bit of the counter: a falling-edge toggle flip-flop with synchronous
// reset and a parallel-load override. q and qbar are both registered so that
// qbar is never a combinational inversion hanging off the cell.
//
// Ports
//   clk  : in  - clock, state changes on the falling edge
//   rst  : in  - synchronous active-high reset (q=0, qbar=1), highest priority
//   ld   : in  - load override, q takes d
//   d    : in  - load data
//   t    : in  - toggle request
//   q    : out - cell state
//   qbar : out - registered complement of q
// -----------------------------------------------------------------------------
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q,
    output logic qbar
);

    logic bit_d;
    logic bit_q;
    logic bitn_d;
    logic bitn_q;

    always_comb begin
        bit_d = bit_q;
        if (rst) begin
            bit_d = 1'b0;
        end else if (ld) begin
            bit_d = d;
        end else if (t) begin
            bit_d = ~bit_q;
        end
        bitn_d = ~bit_d;
    end

    // NOTE: registers use non-blocking assignment so every cell samples the
    // pre-edge state of its neighbours; blocking here would race the chain.
    always_ff @(negedge clk) begin
        bit_q  <= bit_d;
        bitn_q <= bitn_d;
    end

    assign q    = bit_q;
    assign qbar = bitn_q;

endmodule

// File: rtl/sync_up_counter.sv
// -----------------------------------------------------------------------------
// sync_up_counter
//
// Modulo-MODULUS synchronous up counter built from WIDTH toggle cells.
// Priority on each falling edge: rst > load > en > hold. Loads are clamped to
// MODULUS-1, so the count never leaves 0..MODULUS-1.
//
// Parameters
//   WIDTH   : counter width, 1..16
//   MODULUS : sequence length, 2..2^WIDTH
//
// Ports
//   clk      : in  - clock, state changes on the falling edge
//   rst      : in  - synchronous active-high reset
//   en       : in  - count enable / cascade carry-in
//   load     : in  - parallel load strobe
//   load_val : in  - load data (clamped to MODULUS-1)
//   q        : out - current count
//   qbar     : out - registered complement of q
//   tc       : out - terminal count, q == MODULUS-1 (combinational)
//   co       : out - carry-out to next stage's en (combinational)
//   wrap     : out - one-cycle pulse after a MODULUS-1 -> 0 transition
// -----------------------------------------------------------------------------
module sync_up_counter
    import sync_up_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             co,
    output logic             wrap
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_param_check
        $error("sync_up_counter: WIDTH=%0d MODULUS=%0d out of range", WIDTH, MODULUS);
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 32'd1);

    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] t;
    logic             wrap_d;
    logic             wrap_q;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        load_clamped = WIDTH'(clamp_load(32'(load_val), MODULUS));
        tc           = (q == MAX_COUNT);
        co           = tc & en & ~load & ~rst;

        // Reset is applied inside the cells, so nxt only covers load/count/hold.
        nxt = q;
        if (load) begin
            nxt = load_clamped;
        end else if (en) begin
            // Explicit wrap handles non-power-of-two moduli; for 2^WIDTH it
            // matches the natural overflow of q + 1.
            nxt = tc ? '0 : q + WIDTH'(1);
        end

        // Toggle exactly the bits that differ; for plain counting with a
        // power-of-two modulus this is the en & q[0] & ... & q[i-1] chain.
        t = q ^ nxt;

        // co already excludes rst and load, so it is the wrap condition.
        wrap_d = co;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .ld   (load),
            .d    (load_clamped[i]),
            .t    (t[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule
